// File: rtl/read_resp_chan_mngr_pkg.sv
// Shared definitions for the read response channel manager.
// RD_RESP_QUEUE2_EN selects a two-entry request queue; otherwise one entry.
package read_resp_chan_mngr_pkg;

   // Responder FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MRD  = 2'd1,
      ST_BEAT = 2'd2
   } rrc_state_e;

   localparam int BURST_BEATS = 4;
   localparam int ID_W        = 4;
   localparam int BEAT_W      = 32;
   localparam int LINE_W      = BURST_BEATS * BEAT_W;
   localparam int CNT_W       = 2;

`ifdef RD_RESP_QUEUE2_EN
   localparam int RQ_DEPTH = 2;
`else
   localparam int RQ_DEPTH = 1;
`endif

   // Pick beat `cnt` out of a captured line; beat 0 is the least significant word.
   function automatic logic [BEAT_W-1:0] beat_select(input logic [LINE_W-1:0] line,
                                                     input logic [CNT_W-1:0]  cnt);
      logic [BEAT_W-1:0] b;
      b = '0;
      case (cnt)
         2'd0:    b = line[31:0];
         2'd1:    b = line[63:32];
         2'd2:    b = line[95:64];
         2'd3:    b = line[127:96];
         default: b = '0;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/read_resp_chan_mngr_rd_req_queue.sv
// Small synchronous FIFO holding accepted read requests ({id, line index}).
// Entry 0 is always the head; a pop shifts the remaining entries down.
module rd_req_queue
   import read_resp_chan_mngr_pkg::*;
#(
   parameter int DEPTH = 1,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic             empty_o,
   output logic             full_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;

   // Next-state: pop first (shift down), then push into the first free slot
   always_comb begin
      mem_d = mem_q;
      cnt_d = cnt_q;
      if (pop_i && (cnt_q != '0)) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            mem_d[i] = mem_q[i+1];
         end
         mem_d[DEPTH-1] = '0;
         cnt_d          = cnt_q - CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
      if (push_i && (cnt_d != CW'(DEPTH))) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == cnt_d) begin
               mem_d[i] = push_data_i;
            end else begin
               mem_d[i] = mem_d[i];
            end
         end
         cnt_d = cnt_d + CW'(1);
      end else begin
         cnt_d = cnt_d;
      end
   end

   // Storage and occupancy registers, cleared by the synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
         mem_q <= mem_d;
      end
   end

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign head_o  = mem_q[0];

endmodule

// File: rtl/read_resp_chan_mngr.sv
// Target-side AXI-style read responder: queues AR requests, fetches one
// 128-bit line per request from a synchronous memory port and returns it as
// a fixed 4-beat, 32-bit R burst. Define RD_RESP_QUEUE2_EN for a 2-deep
// request queue (arready = !full); default is 1-deep (arready = empty).
module read_resp_chan_mngr
   import read_resp_chan_mngr_pkg::*;
#(
   parameter int MEM_AW = 12
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                arvalid,
   output logic                arready,
   input  logic [ID_W-1:0]     arid,
   input  logic [31:0]         araddr,
   output logic                rvalid,
   input  logic                rready,
   output logic [ID_W-1:0]     rid,
   output logic [BEAT_W-1:0]   rdata,
   output logic                rlast,
   output logic                mem_re,
   output logic [MEM_AW-1:0]   mem_raddr,
   input  logic                mem_rvalid,
   input  logic [LINE_W-1:0]   mem_rdata
);

   localparam int ENT_W = ID_W + MEM_AW;

   rrc_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LINE_W-1:0] line_q, line_d;

   logic              q_push_s;
   logic              q_pop_s;
   logic              q_empty_s;
   logic              q_full_s;
   logic [ENT_W-1:0]  q_push_data_s;
   logic [ENT_W-1:0]  q_head_s;
   logic [ID_W-1:0]   head_id_s;
   logic [MEM_AW-1:0] head_idx_s;
   logic              in_beat_s;
   logic              mem_re_s;
   logic              unused_addr_s;

   // Only the line index bits of the address are meaningful
   assign unused_addr_s = ^{araddr[31:MEM_AW+4], araddr[3:0]};

`ifdef RD_RESP_QUEUE2_EN
   assign arready = !q_full_s;
`else
   assign arready = q_empty_s;
`endif

   assign q_push_s      = arvalid && arready;
   assign q_push_data_s = {arid, araddr[MEM_AW+3:4]};
   assign in_beat_s     = (state_q == ST_BEAT);
   // The request leaves the queue only on the final-beat handshake
   assign q_pop_s       = in_beat_s && rready && (cnt_q == 2'd3);
   assign head_id_s     = q_head_s[ENT_W-1:MEM_AW];
   assign head_idx_s    = q_head_s[MEM_AW-1:0];

   rd_req_queue #(
      .DEPTH (RQ_DEPTH),
      .WIDTH (ENT_W)
   ) u_rd_req_queue (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (q_push_s),
      .push_data_i (q_push_data_s),
      .pop_i       (q_pop_s),
      .empty_o     (q_empty_s),
      .full_o      (q_full_s),
      .head_o      (q_head_s)
   );

   // FSM next-state, line capture and beat counter
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      line_d   = line_q;
      mem_re_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!q_empty_s) begin
               mem_re_s = 1'b1;
               state_d  = ST_MRD;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_MRD: begin
            if (mem_rvalid) begin
               line_d  = mem_rdata;
               cnt_d   = 2'd0;
               state_d = ST_BEAT;
            end else begin
               state_d = ST_MRD;
            end
         end
         ST_BEAT: begin
            if (rready) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_BEAT;
               end
            end else begin
               state_d = ST_BEAT;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
         end
      endcase
   end

   // State, counter and line registers; a reset abandons any burst in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 2'd0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
      end
   end

   // R and memory outputs decoded from registered state only, so they stay
   // stable while a beat is stalled and are zero outside their active phase
   always_comb begin
      rvalid    = in_beat_s;
      mem_re    = mem_re_s;
      if (in_beat_s) begin
         rid   = head_id_s;
         rdata = beat_select(line_q, cnt_q);
         rlast = (cnt_q == 2'd3);
      end else begin
         rid   = '0;
         rdata = '0;
         rlast = 1'b0;
      end
      if (mem_re_s) begin
         mem_raddr = head_idx_s;
      end else begin
         mem_raddr = '0;
      end
   end

endmodule

// File: tb/tb_read_resp_chan_mngr.sv
// Scoreboard bench for read_resp_chan_mngr: stimulus pushes expected beats and
// memory addresses; a negedge monitor and a memory model pop and compare.
module tb_read_resp_chan_mngr;

   logic         clk;
   logic         rst_n;
   logic         arvalid;
   logic         arready;
   logic [3:0]   arid;
   logic [31:0]  araddr;
   logic         rvalid;
   logic         rready;
   logic [3:0]   rid;
   logic [31:0]  rdata;
   logic         rlast;
   logic         mem_re;
   logic [11:0]  mem_raddr;
   logic         mem_rvalid;
   logic         mem_rvalid_m;
   logic         stray_rvalid;
   logic [127:0] mem_rdata;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic        last;
   } beat_t;

   beat_t       sb[$];
   logic [11:0] addr_q[$];
   int          last_hs_list[$];
   int          mre_list[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int hs_count = 0;
   int b0_cyc   = 0;
   int ar_cyc   = 0;

   assign mem_rvalid = mem_rvalid_m | stray_rvalid;

   read_resp_chan_mngr #(.MEM_AW(12)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .arvalid    (arvalid),
      .arready    (arready),
      .arid       (arid),
      .araddr     (araddr),
      .rvalid     (rvalid),
      .rready     (rready),
      .rid        (rid),
      .rdata      (rdata),
      .rlast      (rlast),
      .mem_re     (mem_re),
      .mem_raddr  (mem_raddr),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter, read at negedges
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] line_of(input logic [11:0] idx);
      case (idx)
         12'h012: return 128'h4444_4444_3333_3333_2222_2222_1111_1111;
         12'h034: return 128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001;
         12'h056: return 128'h8765_4321_0FED_CBA9_1357_9BDF_DEAD_BEEF;
         default: return 128'h0;
      endcase
   endfunction

   // Memory model: checks line index, returns the line two cycles after mem_re
   initial begin
      logic [11:0] a;
      mem_rvalid_m = 1'b0;
      mem_rdata    = 128'h0;
      forever begin
         @(negedge clk);
         if (mem_re && rst_n) begin
            a = mem_raddr;
            mre_list.push_back(cyc);
            if (addr_q.size() == 0) begin
               chk("unexpected_mem_re", 32'd1, 32'd0);
            end else begin
               chk("mem_raddr", {20'd0, a}, {20'd0, addr_q.pop_front()});
            end
            @(posedge clk);
            @(posedge clk);
            #1;
            mem_rvalid_m = 1'b1;
            mem_rdata    = line_of(a);
            @(posedge clk);
            #1;
            mem_rvalid_m = 1'b0;
         end
      end
   end

   // R monitor: compares each handshaken beat and checks stall stability
   initial begin
      logic  held;
      beat_t h;
      beat_t e;
      int    bidx;
      held = 1'b0;
      bidx = 0;
      h    = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held = 1'b0;
            bidx = 0;
         end else begin
            if (held) begin
               chk("stall_rvalid", {31'd0, rvalid}, 32'd1);
               chk("stall_rid",    {28'd0, rid},    {28'd0, h.id});
               chk("stall_rdata",  rdata,           h.data);
               chk("stall_rlast",  {31'd0, rlast},  {31'd0, h.last});
            end
            if (rvalid && rready) begin
               held = 1'b0;
               hs_count++;
               if (bidx == 0) b0_cyc = cyc;
               if (rlast) begin
                  last_hs_list.push_back(cyc);
                  bidx = 0;
               end else begin
                  bidx++;
               end
               if (sb.size() == 0) begin
                  chk("unexpected_beat", {28'd0, rid}, 32'hFFFF_FFFF);
               end else begin
                  e = sb.pop_front();
                  chk("beat_rid",   {28'd0, rid},   {28'd0, e.id});
                  chk("beat_rdata", rdata,          e.data);
                  chk("beat_rlast", {31'd0, rlast}, {31'd0, e.last});
               end
            end else if (rvalid) begin
               held = 1'b1;
               h    = {rid, rdata, rlast};
            end else begin
               held = 1'b0;
            end
         end
      end
   end

   // Issue one AR (caller sits just after a posedge) and queue its expectations
   task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [11:0] idx,
                          input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
      bit got;
      got     = 1'b0;
      arvalid = 1'b1;
      arid    = id;
      araddr  = addr;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (arready) begin
            got = 1'b1;
            break;
         end
      end
      if (got) begin
         ar_cyc = cyc;
         addr_q.push_back(idx);
         sb.push_back({id, w0, 1'b0});
         sb.push_back({id, w1, 1'b0});
         sb.push_back({id, w2, 1'b0});
         sb.push_back({id, w3, 1'b1});
         @(posedge clk);
         #1;
      end else begin
         chk("ar_accept_timeout", 32'd0, 32'd1);
      end
      arvalid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int k = 0; k < 300; k++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
         #1;
      end
      chk(name, sb.size(), 32'd0);
   endtask

   task automatic wait_rvalid();
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (rvalid) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      chk("rvalid_timeout", {31'd0, seen}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int nv;
      logic [6:0] pat;
      rst_n        = 1'b0;
      arvalid      = 1'b0;
      arid         = 4'h0;
      araddr       = 32'h0;
      rready       = 1'b0;
      stray_rvalid = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_arready",   {31'd0, arready},   32'd1);
      chk("rst_rvalid",    {31'd0, rvalid},    32'd0);
      chk("rst_rlast",     {31'd0, rlast},     32'd0);
      chk("rst_rid",       {28'd0, rid},       32'd0);
      chk("rst_rdata",     rdata,              32'd0);
      chk("rst_mem_re",    {31'd0, mem_re},    32'd0);
      chk("rst_mem_raddr", {20'd0, mem_raddr}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single read with rready held high
      rready = 1'b1;
      send_ar(4'h5, 32'h0000_0120, 12'h012, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
      chk("t1_mem_re",    {31'd0, mem_re},    32'd1);
      chk("t1_mem_raddr", {20'd0, mem_raddr}, 32'h12);
`ifdef RD_RESP_QUEUE2_EN
      chk("t1_arready", {31'd0, arready}, 32'd1);
`else
      chk("t1_arready", {31'd0, arready}, 32'd0);
`endif
      wait_drain("t1_drain");
      chk("t1_first_beat_latency", b0_cyc - ar_cyc, 32'd4);
      chk("t1_beats_consecutive", last_hs_list[$] - b0_cyc, 32'd3);

      // Backpressure: rready 1,0,0,1,0,1,1 from the first valid beat
      rready = 1'b0;
      base   = hs_count;
      send_ar(4'hA, 32'h0000_0340, 12'h034, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004);
      wait_rvalid();
      pat = 7'b1101001;
      for (int k = 0; k < 7; k++) begin
         rready = pat[k];
         @(posedge clk);
         #1;
      end
      rready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t2_handshakes", hs_count - base, 32'd4);
      chk("t2_rvalid_done", {31'd0, rvalid}, 32'd0);
      wait_drain("t2_drain");

      // Unaligned address maps to the same line, starting at beat 0
      rready = 1'b1;
      send_ar(4'h3, 32'h0000_012C, 12'h012, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
      wait_drain("t3_drain");

      // Back-to-back requests
      rready = 1'b0;
      last_hs_list.delete();
      mre_list.delete();
      send_ar(4'h1, 32'h0000_0340, 12'h034, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004);
      wait_rvalid();
`ifdef RD_RESP_QUEUE2_EN
      chk("t4_arready_second", {31'd0, arready}, 32'd1);
      send_ar(4'h2, 32'h0000_0560, 12'h056, 32'hDEAD_BEEF, 32'h1357_9BDF, 32'h0FED_CBA9, 32'h8765_4321);
      chk("t4_arready_full", {31'd0, arready}, 32'd0);
      arvalid = 1'b1;
      arid    = 4'h3;
      araddr  = 32'h0000_0120;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t4_third_refused", {31'd0, arready}, 32'd0);
      end
      @(posedge clk);
      #1;
      arvalid = 1'b0;
      rready  = 1'b1;
      wait_drain("t4_drain");
      chk("t4_mem_re_count", mre_list.size(), 32'd2);
      if (mre_list.size() == 2 && last_hs_list.size() == 2) begin
         chk("t4_second_mem_re_gap", mre_list[1] - last_hs_list[0], 32'd1);
      end else begin
         chk("t4_burst_count", last_hs_list.size(), 32'd2);
      end
`else
      chk("t4_arready_busy", {31'd0, arready}, 32'd0);
      rready = 1'b1;
      send_ar(4'h2, 32'h0000_0560, 12'h056, 32'hDEAD_BEEF, 32'h1357_9BDF, 32'h0FED_CBA9, 32'h8765_4321);
      if (last_hs_list.size() >= 1) begin
         chk("t4_arready_after_last", ar_cyc - last_hs_list[0], 32'd1);
      end else begin
         chk("t4_first_burst_done", last_hs_list.size(), 32'd1);
      end
      wait_drain("t4_drain");
`endif

      // Reset in the middle of a burst, then a stray memory return
      rready = 1'b1;
      base   = hs_count;
      send_ar(4'h7, 32'h0000_0560, 12'h056, 32'hDEAD_BEEF, 32'h1357_9BDF, 32'h0FED_CBA9, 32'h8765_4321);
      for (int k = 0; k < 100; k++) begin
         if (hs_count - base >= 2) break;
         @(posedge clk);
         #1;
      end
      chk("t5_two_beats", hs_count - base, 32'd2);
      rst_n  = 1'b0;
      rready = 1'b0;
      sb.delete();
      addr_q.delete();
      @(posedge clk);
      #1;
      chk("t5_rvalid",  {31'd0, rvalid},  32'd0);
      chk("t5_arready", {31'd0, arready}, 32'd1);
      chk("t5_rlast",   {31'd0, rlast},   32'd0);
      chk("t5_rdata",   rdata,            32'd0);
      chk("t5_mem_re",  {31'd0, mem_re},  32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      stray_rvalid = 1'b1;
      rready       = 1'b1;
      @(posedge clk);
      #1;
      stray_rvalid = 1'b0;
      nv = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (rvalid) nv++;
      end
      chk("t5_no_stray_beats", nv, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/read_resp_chan_mngr.md
# read_resp_chan_mngr

AXI-style read responder for the target side of the read channel pair. It accepts 4-bit-ID read requests on the AR channel and fetches one 128-bit line from a simple synchronous memory port. It returns that line as a fixed 4-beat, 32-bit R burst with matching `rid` and `rlast` on beat 3. It is the counterpart of the initiator-side read channel manager and sits between the bus arbiter/interconnect and an on-chip memory or peripheral line buffer.

## Interface
- `MEM_AW`, default 12: memory line-index width; `mem_raddr = araddr[MEM_AW+3:4]`.
- `clk` in 1: single clock, all logic rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `arvalid` in 1: read request valid.
- `arready` out 1: request accepted when high with `arvalid`.
- `arid` in 4: request ID.
- `araddr` in 32: byte address; bits [3:0] ignored (line aligned).
- `rvalid` out 1: read data beat valid.
- `rready` in 1: initiator accepts beat.
- `rid` out 4: ID of burst in flight.
- `rdata` out 32: beat data.
- `rlast` out 1: high on beat 3 only.
- `mem_re` out 1: one-cycle memory read strobe.
- `mem_raddr` out MEM_AW: line index.
- `mem_rvalid` in 1: memory line return strobe, any latency ≥1 after `mem_re`.
- `mem_rdata` in 128: returned line.

## Operation
- Request queue holds {arid, line index}; push on `arvalid && arready`; pop on final-beat handshake (`rvalid && rready && rlast`).
- FSM states:
  - IDLE: if queue non-empty, assert `mem_re` for one cycle with the head's index, go to MRD.
  - MRD: wait for `mem_rvalid`; capture `mem_rdata` into a 128-bit line register, load beat counter = 0, go to BEAT.
  - BEAT: `rvalid`=1, `rid`=head ID, `rdata`=line[32*cnt+31:32*cnt], `rlast`=(cnt==3).
    - On `rready`: cnt increments (2-bit).
    - On the cnt==3 handshake: pop the queue, go to IDLE.
- Beat order: beat0 = `mem_rdata[31:0]` … beat3 = `[127:96]`.
- `rvalid`, `rid`, `rdata`, `rlast` stay stable while `rvalid && !rready`.
- `rvalid` never deasserts mid-burst without a handshake.
- `mem_rvalid` outside MRD is ignored.
- No error response; every accepted request yields exactly 4 beats, in acceptance order.
- `arready` does not depend combinationally on `arvalid`.

## Timing
- Reset values: `arready`=1, `rvalid`=0, `rlast`=0, `rid`=0, `rdata`=0, `mem_re`=0, `mem_raddr`=0. FSM=IDLE, queue empty, cnt=0.
- AR handshake at edge N: `mem_re` high during cycle N+1 (IDLE sees non-empty queue), FSM in MRD from N+2.
- `mem_rvalid` sampled at edge M: `rvalid` high from cycle M+1.
- With `rready` held high, beats occupy 4 consecutive cycles.
- After the last handshake, IDLE is held for 1 cycle; the next `mem_re` follows immediately if the queue is non-empty.
- Minimum AR-to-first-beat: 3 cycles plus memory latency.
- Reset asserted mid-burst: at the next edge all state returns to reset values, the in-flight burst is abandoned, and a late `mem_rvalid` is ignored.

## Configuration
- `RD_RESP_QUEUE2_EN` defined:
  - Queue depth 2; `arready` = !full.
  - A second request can be accepted while the first is in MRD/BEAT.
- Undefined:
  - Queue depth 1; `arready` = queue empty.
  - `arready` is low from acceptance until the final-beat handshake edge, then high the following cycle.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE, MRD, BEAT).
  - `BURST_BEATS`=4.
  - AXI ID width constant (4).
- Natural sub-module: `rd_req_queue`, a small synchronous FIFO (depth 1 or 2 per macro) exposing push/pop/empty/full/head.

## Test plan
- Single read: AR id=4'h5, addr=32'h0000_0120; memory returns 128'h4444_4444_3333_3333_2222_2222_1111_1111 after 2 cycles; `rready`=1 → `mem_raddr`=0x12, beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles; `rid`=5 on all beats; `rlast` on beat 4 only.
- Backpressure: as above with `rready` toggling 1,0,0,1,0,1,1 → each beat held stable while stalled, exactly 4 handshakes, no beat skipped or repeated.
- Back-to-back, macro defined: AR id=1 then id=2 issued during burst 1 → second `arready` high; a third AR id=3 is refused while queue full. Bursts return id 1 then id 2, second `mem_re` one cycle after the first `rlast` handshake.
- Macro undefined: second AR held during burst 1 → `arready`=0 until after the `rlast` handshake, then accepted; ordering preserved.
- Unaligned address: araddr=32'h0000_012C → same line as 0x120, still 4 beats starting at line beat 0.
- Reset mid-burst: `rst_n`=0 after beat 2 → next edge `rvalid`=0, `arready`=1; a stray `mem_rvalid` after reset causes no beats.
